reaction_display: RTL and testbench

REACTION_DISPLAY -- requirements
Module: reaction_display

---
 rtl/reaction_display.sv | 258 +++++++++++++++++++++++++
 tb/tb_reaction_display.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reaction_display.sv
// Reaction-time readout: converts a captured 13-bit millisecond value to BCD
// and multiplexes it onto a 4-digit 7-segment display. Option: REACTION_DISPLAY_DP_EN.
module reaction_display #(
  parameter int REFRESH_DIV = 25000,
  parameter int BLINK_STEPS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        waiting_to_start,
  input  logic        test_active,
  input  logic        show_result,
  input  logic [12:0] time_elapsed,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        result_ready
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_STEPS - 1);
  localparam logic [6:0]    SEG_BLANK   = 7'b1111111;
  localparam logic [6:0]    SEG_DASH    = 7'b0111111;
  localparam logic [3:0]    CONV_LAST   = 4'd13;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  // Assert asynchronously, release two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [12:0]   bin_q, bin_d;
  logic [15:0]   bcd_q, bcd_d;
  logic [15:0]   bcd_adj;
  logic          rr_q, rr_d;
  logic          show_prev_q, show_prev_d;
  logic          show_rise;

  logic [RW-1:0] refresh_q, refresh_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [1:0]    digit_q, digit_d;
  logic          advance;

  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  // show_prev resets high so a level held through reset is not a new edge.
  assign show_rise = show_result & ~show_prev_q;
  assign bcd_adj   = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
                      add3(bcd_q[7:4]), add3(bcd_q[3:0])};

  // Converter next-state: capture on rising edge, shift one bit per cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    rr_d        = rr_q;
    show_prev_d = show_result;
    if (show_rise) begin
      state_d = CONVERT;
      cnt_d   = 4'd0;
      bin_d   = time_elapsed;
      bcd_d   = 16'd0;
      rr_d    = 1'b0;
    end else if (!show_result) begin
      state_d = IDLE;
      rr_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rr_d = 1'b0;
        end
        CONVERT: begin
          if (cnt_q == CONV_LAST) begin
            state_d = HOLD;
            rr_d    = 1'b1;
          end else begin
            bcd_d = {bcd_adj[14:0], bin_q[12]};
            bin_d = {bin_q[11:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
          end
        end
        HOLD: begin
          rr_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          rr_d    = 1'b0;
        end
      endcase
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      bin_q       <= 13'd0;
      bcd_q       <= 16'd0;
      rr_q        <= 1'b0;
      show_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      rr_q        <= rr_d;
      show_prev_q <= show_prev_d;
    end
  end

  // Refresh, digit-index and blink counters.
  always_comb begin
    advance     = (refresh_q == REFRESH_MAX);
    refresh_d   = advance ? '0 : (refresh_q + RW'(1));
    digit_d     = digit_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (advance) begin
      digit_d = digit_q + 2'd1;
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      digit_d = digit_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      refresh_q   <= '0;
      digit_q     <= 2'd0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      refresh_q   <= refresh_d;
      digit_q     <= digit_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  logic [3:0] nib;
  logic       zblank;
  logic       lead3, lead2, lead1;

  assign lead3 = (bcd_q[15:12] == 4'd0);
  assign lead2 = lead3 & (bcd_q[11:8] == 4'd0);
  assign lead1 = lead2 & (bcd_q[7:4] == 4'd0);

  // Display content for the currently selected digit, by flag priority.
  always_comb begin
    seg_d  = SEG_BLANK;
    dp_d   = 1'b1;
    an_d   = 4'b1110;
    nib    = bcd_q[3:0];
    zblank = 1'b0;
    case (digit_q)
      2'd0: begin an_d = 4'b1110; nib = bcd_q[3:0];   zblank = 1'b0;  end
      2'd1: begin an_d = 4'b1101; nib = bcd_q[7:4];   zblank = lead1; end
      2'd2: begin an_d = 4'b1011; nib = bcd_q[11:8];  zblank = lead2; end
      2'd3: begin
        an_d = 4'b0111;
        nib  = bcd_q[15:12];
`ifdef REACTION_DISPLAY_DP_EN
        zblank = 1'b0;
`else
        zblank = lead3;
`endif
      end
      default: begin an_d = 4'b1110; nib = bcd_q[3:0]; zblank = 1'b0; end
    endcase
    if (show_result) begin
      if (rr_q) begin
        seg_d = zblank ? SEG_BLANK : seg_of(nib);
`ifdef REACTION_DISPLAY_DP_EN
        dp_d  = (digit_q == 2'd3) ? 1'b0 : 1'b1;
`else
        dp_d  = 1'b1;
`endif
      end else begin
        seg_d = SEG_BLANK;
      end
    end else if (test_active) begin
      seg_d = SEG_BLANK;
    end else if (waiting_to_start) begin
      seg_d = blink_q ? SEG_DASH : SEG_BLANK;
    end else begin
      seg_d = SEG_BLANK;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= 4'b1110;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign seg          = seg_q;
  assign dp           = dp_q;
  assign an           = an_q;
  assign result_ready = rr_q;

endmodule

// File: tb/tb_reaction_display.sv
// Directed bench for reaction_display with REFRESH_DIV=4, BLINK_STEPS=2;
// expected values are hand-computed segment codes and cycle counts.
module tb_reaction_display;

  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
`ifdef REACTION_DISPLAY_DP_EN
  localparam logic       DP3 = 1'b0;
  localparam logic [6:0] LZ3 = S0;
`else
  localparam logic       DP3 = 1'b1;
  localparam logic [6:0] LZ3 = SB;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        waiting_to_start, test_active, show_result;
  logic [12:0] time_elapsed;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        result_ready;

  int vectors = 0;
  int errs = 0;

  reaction_display #(.REFRESH_DIV(4), .BLINK_STEPS(2)) dut (
    .clk(clk), .reset_n(reset_n), .waiting_to_start(waiting_to_start),
    .test_active(test_active), .show_result(show_result),
    .time_elapsed(time_elapsed), .seg(seg), .dp(dp), .an(an),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walk the refresh cycle until every digit has been seen, checking each.
  task automatic check_frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0, input logic dp3);
    logic [3:0] seen;
    int n;
    seen = 4'b0000;
    n = 0;
    while (seen != 4'b1111 && n < 40) begin
      tick();
      n++;
      case (an)
        4'b1110: begin chk({tag, "_d0"}, 16'(seg), 16'(e0)); chk({tag, "_dp0"}, 16'(dp), 16'd1); seen[0] = 1'b1; end
        4'b1101: begin chk({tag, "_d1"}, 16'(seg), 16'(e1)); chk({tag, "_dp1"}, 16'(dp), 16'd1); seen[1] = 1'b1; end
        4'b1011: begin chk({tag, "_d2"}, 16'(seg), 16'(e2)); chk({tag, "_dp2"}, 16'(dp), 16'd1); seen[2] = 1'b1; end
        4'b0111: begin chk({tag, "_d3"}, 16'(seg), 16'(e3)); chk({tag, "_dp3"}, 16'(dp), 16'(dp3)); seen[3] = 1'b1; end
        default: begin
          vectors++;
          errs++;
          $error("FAIL %s_an observed=%b expected=one-low", tag, an);
        end
      endcase
    end
    chk({tag, "_all_digits"}, 16'(seen), 16'hF);
  endtask

  // Raise show_result from low and check result_ready timing (14 cycles).
  task automatic convert(input string tag, input logic [12:0] t);
    time_elapsed = t;
    show_result = 1'b1;
    tick();
    chk({tag, "_rr_cap"}, 16'(result_ready), 16'd0);
    repeat (13) tick();
    chk({tag, "_rr_13"}, 16'(result_ready), 16'd0);
    tick();
    chk({tag, "_rr_14"}, 16'(result_ready), 16'd1);
    tick();
  endtask

  logic [3:0] an_pat [4];
  int n;

  initial begin
    an_pat[0] = 4'b1110; an_pat[1] = 4'b1101; an_pat[2] = 4'b1011; an_pat[3] = 4'b0111;
    reset_n = 1'b0;
    waiting_to_start = 1'b0;
    test_active = 1'b0;
    show_result = 1'b0;
    time_elapsed = 13'd0;
    tick();
    tick();
    chk("rst_seg", 16'(seg), 16'(SB));
    chk("rst_an", 16'(an), 16'b1110);
    chk("rst_dp", 16'(dp), 16'd1);
    chk("rst_rr", 16'(result_ready), 16'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    convert("max", 13'd8191);
    check_frame("max", S8, S1, S9, S1, DP3);

    show_result = 1'b0;
    tick();
    chk("fall_rr", 16'(result_ready), 16'd0);
    convert("seven", 13'd7);
    check_frame("seven", LZ3, SB, SB, S7, DP3);

    show_result = 1'b0;
    tick();
    time_elapsed = 13'd250;
    show_result = 1'b1;
    tick();
    repeat (5) tick();
    show_result = 1'b0;
    time_elapsed = 13'd999;
    tick();
    convert("restart", 13'd999);
    check_frame("restart", LZ3, S9, S9, S9, DP3);

    show_result = 1'b0;
    waiting_to_start = 1'b1;
    n = 0;
    while (an !== 4'b0111 && n < 40) begin tick(); n++; end
    while (an !== 4'b1110 && n < 40) begin tick(); n++; end
    chk("wait_sync", 16'(an), 16'b1110);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      chk("wait_an", 16'(an), 16'(an_pat[k / 4]));
      chk("wait_seg", 16'(seg), 16'((k < 8) ? SD : SB));
    end
    waiting_to_start = 1'b0;

    tick();
    convert("pre", 13'd100);
    show_result = 1'b0;
    tick();
    time_elapsed = 13'd1234;
    show_result = 1'b1;
    tick();
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_seg", 16'(seg), 16'(SB));
    chk("midrst_an", 16'(an), 16'b1110);
    chk("midrst_rr", 16'(result_ready), 16'd0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (23) tick();
    chk("midrst_noconv", 16'(result_ready), 16'd0);
    check_frame("midrst_blank", SB, SB, SB, SB, 1'b1);
    show_result = 1'b0;
    tick();
    convert("after_rst", 13'd1234);
    check_frame("after_rst", S1, S2, S3, S4, DP3);

    test_active = 1'b1;
    tick();
    check_frame("prio", S1, S2, S3, S4, DP3);
    show_result = 1'b0;
    tick();
    chk("active_rr", 16'(result_ready), 16'd0);
    tick();
    check_frame("active", SB, SB, SB, SB, 1'b1);
    test_active = 1'b0;
    tick();
    check_frame("none", SB, SB, SB, SB, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
